axi_txn_limiter: RTL and testbench
==================================

# axi_txn_limiter

Outstanding-transaction limiter and drain controller for one AXI4 link, placed in front of a register cut or a slave port. It gates AW and AR handshakes so that at most `MaxWrTxns` writes and `MaxRdTxns` reads are in flight. It also provides a drain sequence that stops new requests and reports when all outstanding responses have returned, so that software or a power/reset manager can quiesce the link safely.

## Interface
- `MaxWrTxns`, 8: maximum outstanding write transactions, counted from AW handshake to B handshake; must be ≥1.
- `MaxRdTxns`, 8: maximum outstanding read transactions, counted from AR handshake to the last R beat; must be ≥1.
- `axi_req_t`, logic: AXI request struct with `aw`, `aw_valid`, `w`, `w_valid`, `b_ready`, `ar`, `ar_valid`, `r_ready`.
- `axi_resp_t`, logic: AXI response struct with `aw_ready`, `w_ready`, `b`, `b_valid`, `ar_ready`, `r` (with `last`), `r_valid`.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `slv_req_i`  in  axi_req_t  upstream request.
- `slv_resp_o`  out  axi_resp_t  upstream response.
- `mst_req_o`  out  axi_req_t  downstream request.
- `mst_resp_i`  in  axi_resp_t  downstream response.
- `drain_i`  in  1  level request to quiesce the link.
- `drained_o`  out  1  drain complete: no transactions outstanding, no new AW/AR accepted.
- `wr_cnt_o`  out  $clog2(MaxWrTxns+1)  current outstanding writes.
- `rd_cnt_o`  out  $clog2(MaxRdTxns+1)  current outstanding reads.
- `err_o`  out  1  sticky: a B or last-R was seen while the matching count was 0.

## Operation
- All payloads and the W, B and R channels pass through combinationally. Only `aw_valid`/`aw_ready` and `ar_valid`/`ar_ready` are gated.
- AW is allowed when `wr_cnt < MaxWrTxns` and the state permits. Otherwise `mst_req_o.aw_valid=0` and `slv_resp_o.aw_ready=0`. The AR channel follows the same rule with `rd_cnt`.
- Write counter: +1 on downstream AW handshake, −1 on B handshake. Both in the same cycle leave it unchanged.
- Read counter: +1 on AR handshake, −1 on an R handshake with `r.last=1`. Both in the same cycle leave it unchanged.
- Underflow (decrement at 0): the counter stays 0 and `err_o` is set until reset.
- Valid stability: per-channel flag `aw_pend`/`ar_pend` is set when downstream valid is shown without ready and cleared on handshake. While the flag is set, the channel stays enabled regardless of drain, so a presented valid never drops.
- FSM states:
  - RUN: normal gating. `drain_i=1` → DRAIN.
  - DRAIN: new AW/AR are blocked (except pending ones). When both counts are 0 and no pend flag is set → DRAINED. If `drain_i` falls → RUN.
  - DRAINED: `drained_o=1`, new AW/AR are blocked. If `drain_i` falls → RUN.
- W beats are never blocked. Upstream is responsible for not sending W without an AW during drain.

## Timing
- Zero-cycle latency on all forwarded signals.
- Counters, flags and FSM register on the clock edge. A slot freed by B/R in cycle N is usable from cycle N+1; there is no same-cycle bypass from `b_valid`/`r_valid` to `aw_ready`/`ar_ready`.
- When a counter is at its maximum and a release coincides with a request, the request waits one cycle.
- `drained_o` asserts the cycle after the last outstanding response handshakes, given `drain_i` is held. It deasserts the cycle after `drain_i` falls.
- Reset values: state RUN, counts 0, pend flags 0, `drained_o=0`, `err_o=0`. Forwarded outputs follow their inputs, gated by the reset-state counters (i.e. open).
- Reset mid-transaction discards all counts. Downstream must be reset together with this block.

## Configuration
- `AXI_TXN_LIMITER_STATS_EN`:
  - Defined: adds outputs `wr_stall_o` and `rd_stall_o`, each 32 bit. Each is a saturating count of cycles in which upstream valid was high but blocked by the limit (drain-blocked cycles excluded). Both reset to 0.
  - Undefined: these ports and counters do not exist.

## Structure
- Package `axi_txn_limiter_pkg` holds `limiter_state_e` (RUN, DRAIN, DRAINED) and the stats counter width constant.
- Sub-module `txn_counter`, instantiated twice: a parameterised up/down counter with inputs inc/dec, outputs count/full/zero and an underflow pulse.

## Test plan
- Limit fill: with `MaxWrTxns=2`, issue 3 AWs while B is held off. Required: 2 accepted, the third stalls with `aw_ready=0`, `wr_cnt_o=2`. Return one B; the third is accepted the following cycle.
- Simultaneous events: at `rd_cnt=8`, a last-R handshake and a pending AR in the same cycle. Required: count 7 the next cycle, AR accepted one cycle later, count returns to 8.
- Multi-beat read: a 4-beat burst decrements `rd_cnt` only on the beat with `last=1`.
- Drain: 3 reads outstanding, raise `drain_i`. Required: new AR blocked; `drained_o=1` one cycle after the third last-R. Dropping `drain_i` returns to RUN and AR is accepted again.
- Pending valid: downstream holds `aw_ready=0` while `aw_valid` is shown, then `drain_i` rises. Required: `aw_valid` stays high until the handshake, then the count is 1 and `drained_o` waits for the B.
- Error and reset: a B with `wr_cnt=0` sets `err_o=1` and the count stays 0. Asynchronous reset mid-burst clears all counts and `err_o` immediately.

Source files
------------

// File: rtl/axi_txn_limiter_pkg.sv
// rtl/axi_txn_limiter_pkg.sv - shared types, constants and helpers for the AXI transaction limiter
package axi_txn_limiter_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DRAIN   = 2'd1,
        DRAINED = 2'd2
    } limiter_state_e;

    localparam int unsigned StatsCntW = 32;

    // Default AXI channel payloads; integrators may override the top's type parameters
    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } lim_axi_ax_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } lim_axi_w_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } lim_axi_b_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } lim_axi_r_t;

    typedef struct packed {
        lim_axi_ax_t aw;
        logic        aw_valid;
        lim_axi_w_t  w;
        logic        w_valid;
        logic        b_ready;
        lim_axi_ax_t ar;
        logic        ar_valid;
        logic        r_ready;
    } lim_axi_req_t;

    typedef struct packed {
        logic       aw_ready;
        logic       w_ready;
        lim_axi_b_t b;
        logic       b_valid;
        logic       ar_ready;
        lim_axi_r_t r;
        logic       r_valid;
    } lim_axi_resp_t;

    // Saturating increment for the stall statistics counters
    function automatic logic [StatsCntW-1:0] sat_inc(input logic [StatsCntW-1:0] value);
        return (&value) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/axi_txn_limiter_counter.sv
// rtl/axi_txn_limiter_counter.sv - bounded up/down outstanding-transaction counter (txn_counter)
module txn_counter #(
    parameter int unsigned Max  = 8,
    parameter int unsigned CntW = $clog2(Max + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            inc_i,
    input  logic            dec_i,
    output logic [CntW-1:0] count_o,
    output logic            full_o,
    output logic            zero_o,
    output logic            underflow_o
);

    localparam logic [CntW-1:0] MaxCnt = CntW'(Max);

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    // Next count: simultaneous inc/dec cancel, a decrement at zero is flagged and ignored
    always_comb begin
        cnt_d       = cnt_q;
        underflow_o = 1'b0;
        if (inc_i && !dec_i) begin
            if (cnt_q != MaxCnt) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (dec_i && !inc_i) begin
            if (cnt_q == '0) begin
                underflow_o = 1'b1;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    // Count register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_o = cnt_q;
    assign full_o  = (cnt_q == MaxCnt);
    // Zero as seen after this cycle's update lands, so drain can complete without an extra cycle
    assign zero_o  = (cnt_d == '0);

endmodule

// File: rtl/axi_txn_limiter.sv
// rtl/axi_txn_limiter.sv - AXI outstanding-transaction limiter and drain controller (optional AXI_TXN_LIMITER_STATS_EN)
module axi_txn_limiter
    import axi_txn_limiter_pkg::*;
#(
    parameter int unsigned MaxWrTxns  = 8,
    parameter int unsigned MaxRdTxns  = 8,
    parameter type         axi_req_t  = lim_axi_req_t,
    parameter type         axi_resp_t = lim_axi_resp_t,
    localparam int unsigned WrCntW    = $clog2(MaxWrTxns + 1),
    localparam int unsigned RdCntW    = $clog2(MaxRdTxns + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  axi_req_t              slv_req_i,
    output axi_resp_t             slv_resp_o,
    output axi_req_t              mst_req_o,
    input  axi_resp_t             mst_resp_i,
    input  logic                  drain_i,
    output logic                  drained_o,
    output logic [WrCntW-1:0]     wr_cnt_o,
    output logic [RdCntW-1:0]     rd_cnt_o,
`ifdef AXI_TXN_LIMITER_STATS_EN
    output logic                  err_o,
    output logic [StatsCntW-1:0]  wr_stall_o,
    output logic [StatsCntW-1:0]  rd_stall_o
`else
    output logic                  err_o
`endif
);

    limiter_state_e state_q;
    logic           drained_q;
    logic           err_q;
    logic           aw_pend_q, aw_pend_d;
    logic           ar_pend_q, ar_pend_d;

    logic aw_en, ar_en;
    logic aw_vld, ar_vld;
    logic aw_hs, ar_hs;
    logic b_hs, r_last_hs;
    logic wr_full, rd_full;
    logic wr_zero, rd_zero;
    logic wr_uf, rd_uf;
    logic link_idle;

    // A presented valid keeps its channel open; otherwise only RUN with a free slot admits
    assign aw_en = aw_pend_q | ((state_q == RUN) & ~wr_full);
    assign ar_en = ar_pend_q | ((state_q == RUN) & ~rd_full);

    assign aw_vld    = slv_req_i.aw_valid & aw_en;
    assign ar_vld    = slv_req_i.ar_valid & ar_en;
    assign aw_hs     = aw_vld & mst_resp_i.aw_ready;
    assign ar_hs     = ar_vld & mst_resp_i.ar_ready;
    assign b_hs      = mst_resp_i.b_valid & slv_req_i.b_ready;
    assign r_last_hs = mst_resp_i.r_valid & slv_req_i.r_ready & mst_resp_i.r.last;

    // Downstream request: pass-through with AW/AR valid gated
    always_comb begin
        mst_req_o          = slv_req_i;
        mst_req_o.aw_valid = aw_vld;
        mst_req_o.ar_valid = ar_vld;
    end

    // Upstream response: pass-through with AW/AR ready gated
    always_comb begin
        slv_resp_o          = mst_resp_i;
        slv_resp_o.aw_ready = mst_resp_i.aw_ready & aw_en;
        slv_resp_o.ar_ready = mst_resp_i.ar_ready & ar_en;
    end

    txn_counter #(
        .Max  (MaxWrTxns),
        .CntW (WrCntW)
    ) i_wr_counter (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .inc_i       (aw_hs),
        .dec_i       (b_hs),
        .count_o     (wr_cnt_o),
        .full_o      (wr_full),
        .zero_o      (wr_zero),
        .underflow_o (wr_uf)
    );

    txn_counter #(
        .Max  (MaxRdTxns),
        .CntW (RdCntW)
    ) i_rd_counter (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .inc_i       (ar_hs),
        .dec_i       (r_last_hs),
        .count_o     (rd_cnt_o),
        .full_o      (rd_full),
        .zero_o      (rd_zero),
        .underflow_o (rd_uf)
    );

    // Pending flags: set when a gated valid is shown without ready, cleared on handshake
    always_comb begin
        aw_pend_d = aw_pend_q;
        ar_pend_d = ar_pend_q;
        if (aw_hs) begin
            aw_pend_d = 1'b0;
        end else if (aw_vld) begin
            aw_pend_d = 1'b1;
        end
        if (ar_hs) begin
            ar_pend_d = 1'b0;
        end else if (ar_vld) begin
            ar_pend_d = 1'b1;
        end
    end

    // Link is idle once this cycle's updates land: nothing outstanding and no valid on display
    assign link_idle = wr_zero & rd_zero & ~aw_pend_d & ~ar_pend_d;

    // Pending flags and sticky underflow error
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            aw_pend_q <= 1'b0;
            ar_pend_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            aw_pend_q <= aw_pend_d;
            ar_pend_q <= ar_pend_d;
            err_q     <= err_q | wr_uf | rd_uf;
        end
    end

    // Drain FSM with registered drained flag
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= RUN;
            drained_q <= 1'b0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (drain_i) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!drain_i) begin
                        state_q <= RUN;
                    end else if (link_idle) begin
                        state_q   <= DRAINED;
                        drained_q <= 1'b1;
                    end
                end
                DRAINED: begin
                    if (!drain_i) begin
                        state_q   <= RUN;
                        drained_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= RUN;
                    drained_q <= 1'b0;
                end
            endcase
        end
    end

    assign drained_o = drained_q;
    assign err_o     = err_q;

`ifdef AXI_TXN_LIMITER_STATS_EN
    logic [StatsCntW-1:0] wr_stall_q;
    logic [StatsCntW-1:0] rd_stall_q;
    logic                 wr_stall;
    logic                 rd_stall;

    // Only limit-induced stalls count; cycles blocked by drain are excluded via the RUN qualifier
    assign wr_stall = slv_req_i.aw_valid & ~aw_pend_q & (state_q == RUN) & wr_full;
    assign rd_stall = slv_req_i.ar_valid & ~ar_pend_q & (state_q == RUN) & rd_full;

    // Saturating stall-cycle counters
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_stall_q <= '0;
            rd_stall_q <= '0;
        end else begin
            if (wr_stall) begin
                wr_stall_q <= sat_inc(wr_stall_q);
            end
            if (rd_stall) begin
                rd_stall_q <= sat_inc(rd_stall_q);
            end
        end
    end

    assign wr_stall_o = wr_stall_q;
    assign rd_stall_o = rd_stall_q;
`endif

endmodule

// File: tb/tb_axi_txn_limiter.sv
// tb/tb_axi_txn_limiter.sv - directed self-checking bench for axi_txn_limiter
module tb_axi_txn_limiter;
    import axi_txn_limiter_pkg::*;

    logic          clk;
    logic          rst_n;
    logic          drain;
    logic          drained;
    logic          err;
    logic [1:0]    wr_cnt;
    logic [3:0]    rd_cnt;
    lim_axi_req_t  slv_req;
    lim_axi_req_t  mst_req;
    lim_axi_resp_t slv_resp;
    lim_axi_resp_t mst_resp;
`ifdef AXI_TXN_LIMITER_STATS_EN
    logic [31:0]   wr_stall;
    logic [31:0]   rd_stall;
`endif

    int checks = 0;
    int errors = 0;

    axi_txn_limiter #(
        .MaxWrTxns  (2),
        .MaxRdTxns  (8),
        .axi_req_t  (lim_axi_req_t),
        .axi_resp_t (lim_axi_resp_t)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .slv_req_i  (slv_req),
        .slv_resp_o (slv_resp),
        .mst_req_o  (mst_req),
        .mst_resp_i (mst_resp),
        .drain_i    (drain),
        .drained_o  (drained),
        .wr_cnt_o   (wr_cnt),
        .rd_cnt_o   (rd_cnt),
`ifdef AXI_TXN_LIMITER_STATS_EN
        .err_o      (err),
        .wr_stall_o (wr_stall),
        .rd_stall_o (rd_stall)
`else
        .err_o      (err)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        slv_req  = '0;
        mst_resp = '0;
        drain    = 1'b0;
        rst_n    = 1'b0;

        // Reset state and open forwarding during reset
        #2;
        chk("rst_wr_cnt", 32'(wr_cnt), 0);
        chk("rst_rd_cnt", 32'(rd_cnt), 0);
        chk("rst_drained", 32'(drained), 0);
        chk("rst_err", 32'(err), 0);
        slv_req.aw_valid = 1'b1;
        slv_req.aw.addr  = 32'h1000_0040;
        #1;
        chk("rst_aw_fwd", 32'(mst_req.aw_valid), 1);
        chk("aw_addr_fwd", mst_req.aw.addr, 32'h1000_0040);
        slv_req.aw_valid = 1'b0;
        #9;
        rst_n = 1'b1;
        tick();

        // Limit fill with MaxWrTxns=2
        slv_req.aw_valid   = 1'b1;
        slv_req.b_ready    = 1'b1;
        mst_resp.aw_ready  = 1'b1;
        #1;
        chk("fill_aw0_ready", 32'(slv_resp.aw_ready), 1);
        tick();
        chk("fill_cnt1", 32'(wr_cnt), 1);
        chk("fill_aw1_ready", 32'(slv_resp.aw_ready), 1);
        tick();
        chk("fill_cnt2", 32'(wr_cnt), 2);
        chk("fill_aw2_stall_ready", 32'(slv_resp.aw_ready), 0);
        chk("fill_aw2_stall_valid", 32'(mst_req.aw_valid), 0);
        mst_resp.b_valid = 1'b1;
        #1;
        chk("fill_no_bypass", 32'(slv_resp.aw_ready), 0);
        chk("b_fwd", 32'(slv_resp.b_valid), 1);
        tick();
        mst_resp.b_valid = 1'b0;
        #1;
        chk("fill_cnt_after_b", 32'(wr_cnt), 1);
        chk("fill_aw2_accept", 32'(slv_resp.aw_ready), 1);
        tick();
        slv_req.aw_valid = 1'b0;
        #1;
        chk("fill_cnt_refull", 32'(wr_cnt), 2);
        mst_resp.b_valid = 1'b1;
        tick();
        tick();
        mst_resp.b_valid = 1'b0;
        #1;
        chk("fill_cnt_empty", 32'(wr_cnt), 0);
        chk("err_clean", 32'(err), 0);

        // Underflow: B with nothing outstanding
        mst_resp.b_valid = 1'b1;
        tick();
        mst_resp.b_valid = 1'b0;
        #1;
        chk("uf_cnt_stays0", 32'(wr_cnt), 0);
        chk("uf_err_set", 32'(err), 1);

        // Fill reads to 8
        slv_req.ar_valid  = 1'b1;
        slv_req.r_ready   = 1'b1;
        mst_resp.ar_ready = 1'b1;
        repeat (8) tick();
        chk("rd_full_cnt", 32'(rd_cnt), 8);
        chk("rd_full_block", 32'(slv_resp.ar_ready), 0);

        // Last-R and pending AR in the same cycle at the limit
        mst_resp.r_valid = 1'b1;
        mst_resp.r.last  = 1'b1;
        mst_resp.r.data  = 32'hCAFE_F00D;
        #1;
        chk("simul_no_bypass", 32'(slv_resp.ar_ready), 0);
        chk("r_data_fwd", slv_resp.r.data, 32'hCAFE_F00D);
        tick();
        mst_resp.r_valid = 1'b0;
        #1;
        chk("simul_cnt7", 32'(rd_cnt), 7);
        chk("simul_ar_accept", 32'(slv_resp.ar_ready), 1);
        tick();
        slv_req.ar_valid = 1'b0;
        #1;
        chk("simul_cnt8", 32'(rd_cnt), 8);

        // Four-beat burst: only the last beat releases a slot
        mst_resp.r_valid = 1'b1;
        mst_resp.r.last  = 1'b0;
        repeat (3) tick();
        chk("burst_mid_cnt", 32'(rd_cnt), 8);
        mst_resp.r.last = 1'b1;
        tick();
        mst_resp.r_valid = 1'b0;
        #1;
        chk("burst_last_cnt", 32'(rd_cnt), 7);
        mst_resp.r_valid = 1'b1;
        repeat (4) tick();
        mst_resp.r_valid = 1'b0;
        #1;
        chk("rd_cnt3", 32'(rd_cnt), 3);

        // Drain with three reads outstanding
        drain = 1'b1;
        tick();
        slv_req.ar_valid = 1'b1;
        #1;
        chk("drain_ar_block_ready", 32'(slv_resp.ar_ready), 0);
        chk("drain_ar_block_valid", 32'(mst_req.ar_valid), 0);
        mst_resp.r_valid = 1'b1;
        tick();
        tick();
        chk("drain_not_yet", 32'(drained), 0);
        chk("drain_rd_cnt1", 32'(rd_cnt), 1);
        tick();
        mst_resp.r_valid = 1'b0;
        #1;
        chk("drained_set", 32'(drained), 1);
        chk("drain_rd_cnt0", 32'(rd_cnt), 0);
        chk("drained_ar_block", 32'(slv_resp.ar_ready), 0);
        drain = 1'b0;
        #1;
        chk("drained_hold", 32'(drained), 1);
        tick();
        chk("undrain_clear", 32'(drained), 0);
        chk("undrain_ar_accept", 32'(slv_resp.ar_ready), 1);
        tick();
        slv_req.ar_valid = 1'b0;
        #1;
        chk("undrain_rd_cnt", 32'(rd_cnt), 1);
        mst_resp.r_valid = 1'b1;
        tick();
        mst_resp.r_valid = 1'b0;
        #1;

        // Pending AW valid survives a drain request
        mst_resp.aw_ready = 1'b0;
        slv_req.aw_valid  = 1'b1;
        tick();
        drain = 1'b1;
        tick();
        chk("pend_valid_held", 32'(mst_req.aw_valid), 1);
        chk("pend_not_drained", 32'(drained), 0);
        tick();
        chk("pend_valid_held2", 32'(mst_req.aw_valid), 1);
        mst_resp.aw_ready = 1'b1;
        tick();
        chk("pend_cnt1", 32'(wr_cnt), 1);
        chk("pend_new_blocked", 32'(mst_req.aw_valid), 0);
        chk("pend_wait_b", 32'(drained), 0);
        slv_req.aw_valid = 1'b0;
        mst_resp.b_valid = 1'b1;
        tick();
        mst_resp.b_valid = 1'b0;
        #1;
        chk("pend_drained_after_b", 32'(drained), 1);
        chk("pend_wr_cnt0", 32'(wr_cnt), 0);
        drain = 1'b0;
        tick();
        chk("pend_undrain", 32'(drained), 0);

        // Asynchronous reset in the middle of traffic
        slv_req.aw_valid  = 1'b1;
        slv_req.ar_valid  = 1'b1;
        mst_resp.aw_ready = 1'b1;
        mst_resp.ar_ready = 1'b1;
        tick();
        tick();
        chk("pre_rst_wr_cnt", 32'(wr_cnt), 2);
        chk("pre_rst_rd_cnt", 32'(rd_cnt), 2);
        chk("pre_rst_err", 32'(err), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_wr_cnt", 32'(wr_cnt), 0);
        chk("async_rst_rd_cnt", 32'(rd_cnt), 0);
        chk("async_rst_err", 32'(err), 0);
        chk("async_rst_aw_open", 32'(mst_req.aw_valid), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
